// File: rtl/bit_stream_driver.sv
// ============================================================================
// bit_stream_driver: MSB-first serializer/deserializer for 1-bit reactive devices.
// Optional response compare: define BIT_STREAM_DRIVER_COMPARE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module bit_stream_driver #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             dev_in,
  input  logic             dev_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
  ,
  input  logic [WIDTH-1:0] exp_data,
  output logic             rx_mismatch
`endif
);

  localparam int CW = $clog2(WIDTH + 8);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_HOLD = 2'd2;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH + LATENCY - 1);
  localparam logic [CW-1:0] C_TX_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_LAT      = CW'(LATENCY);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic             dev_in_q, dev_in_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rx_next;

  assign tx_ready = (state_q == C_IDLE) && !rst;
  assign rx_next  = {rx_sh_q[WIDTH-2:0], dev_out};

  // dev_in is registered, so it is computed one cycle ahead: the handshake
  // launches the MSB and the shift register always holds the next bit on top.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    dev_in_d = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d  = C_RUN;
          cnt_d    = '0;
          tx_sh_d  = {tx_data[WIDTH-2:0], 1'b0};
          dev_in_d = tx_data[WIDTH-1];
        end
      end
      C_RUN: begin
        cnt_d   = cnt_q + CW'(1);
        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
        if (cnt_q < C_TX_LAST) begin
          dev_in_d = tx_sh_q[WIDTH-1];
        end
        if (cnt_q >= C_LAT) begin
          rx_sh_d = rx_next;
        end
        if (cnt_q == C_CNT_LAST) begin
          state_d = C_HOLD;
        end
      end
      C_HOLD: begin
        if (rx_ready) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
    rx_valid_d = (state_d == C_HOLD);
    busy_d     = (state_d != C_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_IDLE;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      dev_in_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      dev_in_q   <= dev_in_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign dev_in   = dev_in_q;
  assign rx_data  = rx_sh_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

`ifdef BIT_STREAM_DRIVER_COMPARE_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             mismatch_q, mismatch_d;

  // The verdict is formed from the final shifted word so it rises with rx_valid.
  always_comb begin
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    case (state_q)
      C_IDLE: begin
        if (tx_valid && tx_ready) begin
          exp_d = exp_data;
        end
      end
      C_RUN: begin
        if (cnt_q == C_CNT_LAST) begin
          mismatch_d = (rx_next != exp_q);
        end
      end
      C_HOLD: begin
        if (rx_ready) begin
          mismatch_d = 1'b0;
        end
      end
      default: mismatch_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign rx_mismatch = mismatch_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bit_stream_driver.sv
// Bench for bit_stream_driver: registered device (LATENCY=1) and a
// combinational inverter (LATENCY=0), directed plus randomized words.
`default_nettype none

module tb_bit_stream_driver;
  localparam int W = 8;
  localparam int L = 1;
  typedef logic [W-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;

  word_t tx_data = '0;
  logic  tx_valid = 1'b0;
  logic  tx_ready;
  logic  dev_in;
  logic  dev_out;
  word_t rx_data;
  logic  rx_valid;
  logic  rx_ready = 1'b0;
  logic  busy;

  word_t tx_data0 = '0;
  logic  tx_valid0 = 1'b0;
  logic  tx_ready0;
  logic  dev_in0;
  logic  dev_out0;
  word_t rx_data0;
  logic  rx_valid0;
  logic  rx_ready0 = 1'b0;
  logic  busy0;

  logic  inv = 1'b0;
  logic  dev_q;

`ifdef BIT_STREAM_DRIVER_COMPARE_EN
  word_t exp_data = '0;
  word_t exp_word = '0;
  logic  rx_mismatch;
  word_t exp_data0 = '0;
  logic  rx_mismatch0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Device models: one-register pass/invert device, and a pure inverter.
  always @(posedge clk) dev_q <= rst ? 1'b0 : (dev_in ^ inv);
  assign dev_out  = dev_q;
  assign dev_out0 = ~dev_in0;

  bit_stream_driver #(.WIDTH(W), .LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dev_in(dev_in), .dev_out(dev_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy)
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    , .exp_data(exp_data), .rx_mismatch(rx_mismatch)
`endif
  );

  bit_stream_driver #(.WIDTH(W), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .dev_in(dev_in0), .dev_out(dev_out0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .busy(busy0)
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    , .exp_data(exp_data0), .rx_mismatch(rx_mismatch0)
`endif
  );

  function automatic word_t dev_model(input word_t w, input logic invert);
    return invert ? ~w : w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transfer on the LATENCY=1 instance with optional rx backpressure.
  task automatic xfer(input word_t w, input logic invert, input int stall);
    int    guard;
    word_t want;
    inv   = invert;
    want  = dev_model(w, invert);
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("tx_ready_idle", 32'(tx_ready), 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    exp_data = exp_word;
`endif
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = word_t'($urandom);
    for (int i = 0; i < W; i++) begin
      check("dev_in_bit", 32'(dev_in), 32'(w[W-1-i]));
      check("busy_run", 32'(busy), 32'd1);
      check("tx_ready_run", 32'(tx_ready), 32'd0);
      check("rx_valid_run", 32'(rx_valid), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < L; i++) begin
      check("dev_in_drain", 32'(dev_in), 32'd0);
      check("rx_valid_drain", 32'(rx_valid), 32'd0);
      @(negedge clk);
    end
    check("rx_valid_rise", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'(want));
    check("dev_in_hold", 32'(dev_in), 32'd0);
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    check("rx_mismatch", 32'(rx_mismatch), 32'(want != exp_word));
`endif
    for (int s = 0; s < stall; s++) begin
      rx_ready = 1'b0;
      tx_valid = 1'b1;
      tx_data  = word_t'(17);
      @(negedge clk);
      check("hold_valid", 32'(rx_valid), 32'd1);
      check("hold_data", 32'(rx_data), 32'(want));
      check("hold_tx_ready", 32'(tx_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rx_valid", 32'(rx_valid), 32'd0);
    check("idle_tx_ready", 32'(tx_ready), 32'd1);
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    check("idle_mismatch", 32'(rx_mismatch), 32'd0);
`endif
  endtask

  // Transfer on the LATENCY=0 instance through the combinational inverter.
  task automatic xfer0(input word_t w);
    int guard;
    guard = 0;
    while (tx_ready0 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("l0_tx_ready", 32'(tx_ready0), 32'd1);
    tx_data0  = w;
    tx_valid0 = 1'b1;
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    exp_data0 = ~w;
`endif
    @(negedge clk);
    tx_valid0 = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("l0_dev_in", 32'(dev_in0), 32'(w[W-1-i]));
      check("l0_rx_valid_run", 32'(rx_valid0), 32'd0);
      @(negedge clk);
    end
    check("l0_rx_valid", 32'(rx_valid0), 32'd1);
    check("l0_rx_data", 32'(rx_data0), 32'(dev_model(w, 1'b1)));
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    check("l0_mismatch", 32'(rx_mismatch0), 32'd0);
`endif
    rx_ready0 = 1'b1;
    @(negedge clk);
    rx_ready0 = 1'b0;
    check("l0_idle_busy", 32'(busy0), 32'd0);
  endtask

  initial begin
    logic  seen;
    word_t w;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_tx_ready0", 32'(tx_ready0), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("post_rst_dev_in", 32'(dev_in), 32'd0);
    check("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("post_rst_rx_data", 32'(rx_data), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    check("post_rst_mismatch", 32'(rx_mismatch), 32'd0);
`endif
    @(negedge clk);

    // Loopback and inverting device
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    exp_word = word_t'(8'hA5);
`endif
    xfer(word_t'(8'hA5), 1'b0, 0);
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    exp_word = word_t'(8'hC3);
`endif
    xfer(word_t'(8'h3C), 1'b1, 0);
    xfer0(word_t'(8'h3C));

    // Backpressure with a rejected word pulsed during HOLD, then that word
    xfer(word_t'(8'h5A), 1'b0, 5);
    xfer(word_t'(8'h11), 1'b0, 0);

`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    exp_word = word_t'(8'hA4);
    xfer(word_t'(8'hA5), 1'b0, 0);
`endif

    // Reset in the middle of RUN at cnt=3
    tx_data  = word_t'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_tx_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dev_in", 32'(dev_in), 32'd0);
    check("abort_rx_valid", 32'(rx_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < W + L + 4; i++) begin
      @(negedge clk);
      seen = seen | rx_valid;
    end
    check("abort_no_rx_valid", 32'(seen), 32'd0);
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
    exp_word = word_t'(8'h0F);
`endif
    xfer(word_t'(8'h0F), 1'b0, 0);

    // Randomized words, devices and stalls
    for (int k = 0; k < 12; k++) begin
      logic r_inv;
      w     = word_t'($urandom);
      r_inv = ($urandom_range(0, 1) == 1);
`ifdef BIT_STREAM_DRIVER_COMPARE_EN
      exp_word = ($urandom_range(0, 1) == 1) ? dev_model(w, r_inv) : word_t'($urandom);
`endif
      xfer(w, r_inv, int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 4; k++) begin
      xfer0(word_t'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
